fp_op_scheduler: RTL and testbench
==================================

FP_OP_SCHEDULER -- requirements
Module: fp_op_scheduler

Interface
REQ-001 Parameter TIMEOUT, default 64, is the maximum number of WAIT cycles allowed for fpu_done before the operation is aborted.
REQ-002 Parameter NAN_VALUE, default 32'h7FC00000, is the data returned on abort (quiet NaN).
REQ-003 clk  input  1  sole clock; all logic on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 reqN_valid (N=0,1)  input  1  channel N presents an operation.
REQ-006 reqN_ready  output  1  channel N operation accepted this cycle.
REQ-007 reqN_op  input  2  operation select: 00 add, 01 sub, 10 mul, 11 div.
REQ-008 reqN_a, reqN_b  input  32  IEEE 754 single-precision operands.
REQ-009 rspN_valid  output  1  channel N result held.
REQ-010 rspN_ready  input  1  channel N consumes its result.
REQ-011 rspN_data  output  32  IEEE 754 result.
REQ-012 rspN_err  output  1  result is a timeout abort.
REQ-013 fpu_start  output  1  one-cycle pulse that launches the shared FP unit.
REQ-014 fpu_op, fpu_a, fpu_b  output  2/32/32  operation and operands to the FP unit, stable from fpu_start until fpu_done or abort.
REQ-015 fpu_done  input  1  FP unit result valid pulse.
REQ-016 fpu_result  input  32  FP unit result, sampled when fpu_done=1.
REQ-017 busy  output  1  high in any state except IDLE.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT; IDLE->ISSUE on accept, ISSUE->WAIT unconditionally, WAIT->IDLE on fpu_done or timeout.
REQ-019 Channel N is eligible in IDLE when reqN_valid=1 and rspN_valid=0.
REQ-020 Arbitration is round-robin: if both channels are eligible, grant the channel not granted last; after reset, channel 0 wins first.
REQ-021 reqN_ready is combinational: 1 only in IDLE for the granted eligible channel; at most one ready is high per cycle.
REQ-022 On accept in cycle T, op and operands are latched, and the granted channel is recorded; fpu_start=1 in T+1 (ISSUE) only.
REQ-023 In WAIT, a cycle counter starts at 0 and increments each cycle; fpu_done=1 loads fpu_result into rspN_data, clears rspN_err, and sets rspN_valid in the following cycle.
REQ-024 If the counter reaches TIMEOUT-1 with fpu_done=0, the abort path loads NAN_VALUE into rspN_data, sets rspN_err=1 and rspN_valid=1, and returns to IDLE.
REQ-025 If fpu_done=1 in the timeout cycle, the done path wins and rspN_err=0.
REQ-026 fpu_done outside WAIT is ignored.
REQ-027 rspN_valid holds, with data and err stable, until rspN_ready=1; it then clears the next cycle.
REQ-028 A result may be consumed in the same cycle that the other channel is accepted; the two channels' response buffers are independent.
REQ-029 Latency from accept to rspN_valid is L+2 cycles, where L is the fpu_start-to-fpu_done distance (L>=1).

Reset
REQ-030 rst=1 forces IDLE and clears the counter; the round-robin pointer selects channel 0 next.
REQ-031 rst=1 forces rspN_valid=0, rspN_err=0, rspN_data=0, fpu_start=0, fpu_op/a/b=0, and busy=0.
REQ-032 Reset mid-operation discards the in-flight operation; a later fpu_done is ignored.

Structure
REQ-033 A shared package holds the op encodings (OP_ADD..OP_DIV), the FSM state typedef, and the NAN_VALUE default.
REQ-034 The round-robin grant logic is one sub-module, rr_arbiter2 (2 requests, grant, last-grant register).

Verification
REQ-035 ch0 add 417C0000+40400000 with the FPU model at L=3 -> fpu_start 1 cycle after accept; rsp0_data=41960000, err=0, 5 cycles after accept.
REQ-036 Both channels valid at once, ch0 sub and ch1 mul of 417C0000, 40400000 -> ch0 served first (414C0000), then ch1 (423D0000); a repeat of both requests serves ch1 first.
REQ-037 ch1 div 417C0000/40400000 with rsp1_ready held 0 -> rsp1_data=40A80000 stays stable, and a new req1 is not accepted while ch0 is still served.
REQ-038 FPU model never asserts done, TIMEOUT=8 -> rsp0_data=7FC00000, err=1, 10 cycles after accept; busy drops.
REQ-039 fpu_done in exactly the timeout cycle -> rsp data=fpu_result, err=0.
REQ-040 rst asserted in WAIT, followed by a stray fpu_done -> no rsp_valid; all outputs at reset values; next accept goes to ch0.

Source files
------------

// File: rtl/fp_op_scheduler_pkg.sv
// Shared definitions for the FP operation scheduler:
// op encodings, FSM state type and the abort data value.
package fp_op_scheduler_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10
  } state_e;

  localparam logic [31:0] NAN_DEFAULT = 32'h7FC0_0000;

endpackage

// File: rtl/fp_op_scheduler_arb.sv
// Two-way round-robin arbiter; on a tie the channel
// not granted last wins, channel 0 first after reset.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic last;

  // Tie goes to the channel that did not win last time
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end

  // Remember the winner of every granted request
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (|grant) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/fp_op_scheduler.sv
// Two-channel front end that shares one FP unit,
// with per-channel response buffers and a done timeout.
module fp_op_scheduler
  import fp_op_scheduler_pkg::*;
#(
  parameter int          TIMEOUT   = 64,
  parameter logic [31:0] NAN_VALUE = NAN_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
  output logic        rsp1_err,
  output logic        fpu_start,
  output logic [1:0]  fpu_op,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic        fpu_done,
  input  logic [31:0] fpu_result,
  output logic        busy
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  state_e        state;
  state_e        state_nx;
  logic [CW-1:0] cnt;
  logic          chan;
  logic [1:0]    req;
  logic [1:0]    grant;
  logic          accept;
  logic          expire;
  logic          finish;
  logic [31:0]   res_data;

  assign req[0] = (state == ST_IDLE)
                & req0_valid & ~rsp0_valid;
  assign req[1] = (state == ST_IDLE)
                & req1_valid & ~rsp1_valid;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = |grant;

  assign expire = (state == ST_WAIT)
                & (cnt == CW'(TIMEOUT - 1));
  assign finish = (state == ST_WAIT)
                & (fpu_done | expire);
  assign res_data = fpu_done ? fpu_result
                             : NAN_VALUE;

  assign fpu_start = (state == ST_ISSUE);
  assign busy      = (state != ST_IDLE);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (accept) state_nx = ST_ISSUE;
      ST_ISSUE: state_nx = ST_WAIT;
      ST_WAIT:  if (fpu_done || expire)
                  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // WAIT cycle counter, zero on entry to WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == ST_WAIT) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // Latch the granted operation and its owner
  always_ff @(posedge clk) begin
    if (rst) begin
      chan   <= 1'b0;
      fpu_op <= 2'b00;
      fpu_a  <= '0;
      fpu_b  <= '0;
    end else if (accept) begin
      chan   <= grant[1];
      fpu_op <= grant[1] ? req1_op : req0_op;
      fpu_a  <= grant[1] ? req1_a  : req0_a;
      fpu_b  <= grant[1] ? req1_b  : req0_b;
    end
  end

  // Per-channel response buffers
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_data  <= '0;
      rsp1_err   <= 1'b0;
    end else begin
      if (rsp0_valid && rsp0_ready) begin
        rsp0_valid <= 1'b0;
      end
      if (rsp1_valid && rsp1_ready) begin
        rsp1_valid <= 1'b0;
      end
      if (finish && !chan) begin
        rsp0_valid <= 1'b1;
        rsp0_data  <= res_data;
        rsp0_err   <= ~fpu_done;
      end
      if (finish && chan) begin
        rsp1_valid <= 1'b1;
        rsp1_data  <= res_data;
        rsp1_err   <= ~fpu_done;
      end
    end
  end

endmodule

// File: tb/tb_fp_op_scheduler.sv
// Self-checking bench for fp_op_scheduler with a
// latency-programmable FP unit model and a reference model.
module tb_fp_op_scheduler;
  import fp_op_scheduler_pkg::*;

  localparam int          TO   = 8;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] XA   = 32'h417C_0000;
  localparam logic [31:0] XB   = 32'h4040_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 0, req1_valid = 0;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_op = 0, req1_op = 0;
  logic [31:0] req0_a = 0, req0_b = 0;
  logic [31:0] req1_a = 0, req1_b = 0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 0, rsp1_ready = 0;
  logic [31:0] rsp0_data, rsp1_data;
  logic        rsp0_err, rsp1_err;
  logic        fpu_start;
  logic [1:0]  fpu_op;
  logic [31:0] fpu_a, fpu_b;
  logic        fpu_done = 0;
  logic [31:0] fpu_result = 0;
  logic        busy;

  int passed = 0;
  int total  = 0;
  int pref   = 0;
  int fpu_lat = 0;
  int cd = 0;
  logic [31:0] fres = 0;

  fp_op_scheduler #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .fpu_start(fpu_start), .fpu_op(fpu_op),
    .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_done(fpu_done), .fpu_result(fpu_result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in FP unit: exact results for the reference
  // operands, a scrambled but deterministic value otherwise
  function automatic logic [31:0] fpu_fn(
    input logic [1:0] op,
    input logic [31:0] a, b);
    if (a == XA && b == XB) begin
      case (op)
        OP_ADD:  return 32'h4196_0000;
        OP_SUB:  return 32'h414C_0000;
        OP_MUL:  return 32'h423D_0000;
        default: return 32'h40A8_0000;
      endcase
    end
    return a ^ {b[15:0], b[31:16]} ^ {30'd0, op};
  endfunction

  // FP unit model: done pulse fpu_lat cycles after start,
  // fpu_lat of 0 means the unit never answers
  always @(negedge clk) begin
    if (fpu_start) begin
      cd = fpu_lat;
      fres = fpu_fn(fpu_op, fpu_a, fpu_b);
      fpu_done = 1'b0;
    end else if (cd > 0) begin
      cd = cd - 1;
      fpu_done = (cd == 0);
    end else begin
      fpu_done = 1'b0;
    end
    fpu_result = fpu_done ? fres : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One operation; mask selects requesting channels.
  // Expected winner, latency, data and err come from
  // the round-robin and timeout rules.
  task automatic txn(input logic [1:0] mask,
                     input logic [1:0] op0, op1,
                     input logic [31:0] a, b,
                     input int lat, hold);
    int g, n, elat;
    logic [1:0]  gop;
    logic [31:0] ed, od;
    logic        ee, ov, oe;
    bit abort;
    g = (mask == 2'b11) ? pref : (mask[1] ? 1 : 0);
    gop = g ? op1 : op0;
    abort = (lat == 0) || (lat > TO);
    elat = (abort ? TO : lat) + 2;
    ed = abort ? QNAN : fpu_fn(gop, a, b);
    ee = abort;
    fpu_lat = lat;
    req0_valid = mask[0]; req0_op = op0;
    req0_a = a; req0_b = b;
    req1_valid = mask[1]; req1_op = op1;
    req1_a = a; req1_b = b;
    #1;
    chk("ready0", req0_ready, 32'(g == 0));
    chk("ready1", req1_ready, 32'(g == 1));
    if (g == 0) req1_valid = 0;
    else req0_valid = 0;
    step();
    req0_valid = 0; req1_valid = 0;
    pref = 1 - g;
    chk("start", fpu_start, 1);
    chk("fpu_op", fpu_op, gop);
    chk("fpu_a", fpu_a, a);
    n = 1;
    ov = g ? rsp1_valid : rsp0_valid;
    while (!ov && n < 60) begin
      step();
      n++;
      ov = g ? rsp1_valid : rsp0_valid;
    end
    chk("latency", n, elat);
    od = g ? rsp1_data : rsp0_data;
    oe = g ? rsp1_err : rsp0_err;
    chk("data", od, ed);
    chk("err", oe, ee);
    chk("busy_end", busy, 0);
    for (int i = 0; i < hold; i++) begin
      step();
      od = g ? rsp1_data : rsp0_data;
      ov = g ? rsp1_valid : rsp0_valid;
      chk("hold_valid", ov, 1);
      chk("hold_data", od, ed);
    end
    if (g == 0) rsp0_ready = 1;
    else rsp1_ready = 1;
    step();
    rsp0_ready = 0; rsp1_ready = 0;
    ov = g ? rsp1_valid : rsp0_valid;
    chk("consumed", ov, 0);
  endtask

  initial begin
    int n;
    rst = 1;
    step();
    step();
    rst = 0;
    pref = 0;
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", fpu_start, 0);
    chk("rst_data0", rsp0_data, 0);

    // Tie: ch0 first, then the repeat goes to ch1
    txn(2'b11, OP_SUB, OP_MUL, XA, XB, 3, 0);
    txn(2'b11, OP_SUB, OP_MUL, XA, XB, 3, 0);
    // Single add, L=3, five cycles accept-to-response
    txn(2'b01, OP_ADD, OP_ADD, XA, XB, 3, 1);

    // ch1 div held unconsumed while ch0 is served
    fpu_lat = 2;
    req1_valid = 1; req1_op = OP_DIV;
    req1_a = XA; req1_b = XB;
    #1;
    chk("div_ready1", req1_ready, 1);
    step();
    req1_valid = 0;
    pref = 0;
    n = 1;
    while (!rsp1_valid && n < 60) begin
      step();
      n++;
    end
    chk("div_latency", n, 4);
    chk("div_data", rsp1_data, 32'h40A8_0000);
    chk("div_err", rsp1_err, 0);
    req1_valid = 1;
    req0_valid = 1; req0_op = OP_ADD;
    req0_a = XA; req0_b = XB;
    fpu_lat = 3;
    #1;
    chk("held_ready1", req1_ready, 0);
    chk("held_ready0", req0_ready, 1);
    step();
    req0_valid = 0;
    pref = 1;
    n = 1;
    while (!rsp0_valid && n < 60) begin
      step();
      n++;
    end
    chk("ch0_data", rsp0_data, 32'h4196_0000);
    chk("held_data", rsp1_data, 32'h40A8_0000);
    chk("held_valid", rsp1_valid, 1);
    chk("held_block", req1_ready, 0);
    rsp1_ready = 1;
    step();
    rsp1_ready = 0;
    fpu_lat = 2;
    chk("rsp1_cleared", rsp1_valid, 0);
    chk("reaccept1", req1_ready, 1);
    rsp0_ready = 1;
    step();
    rsp0_ready = 0;
    req1_valid = 0;
    pref = 0;
    chk("rsp0_consumed", rsp0_valid, 0);
    chk("re_start", fpu_start, 1);
    n = 1;
    while (!rsp1_valid && n < 60) begin
      step();
      n++;
    end
    chk("re_data", rsp1_data, 32'h40A8_0000);
    rsp1_ready = 1;
    step();
    rsp1_ready = 0;

    // Timeout abort and done exactly at the limit
    txn(2'b01, OP_ADD, OP_ADD, XA, XB, 0, 2);
    txn(2'b10, OP_MUL, OP_MUL, XA, XB, TO, 1);
    txn(2'b10, OP_MUL, OP_MUL, XA, XB, TO + 1, 0);

    // Reset in WAIT, then a stray done
    fpu_lat = 4;
    req0_valid = 1; req0_op = OP_MUL;
    req0_a = XA; req0_b = XB;
    #1;
    chk("pre_rst_ready0", req0_ready, 1);
    step();
    req0_valid = 0;
    step();
    step();
    chk("pre_rst_busy", busy, 1);
    rst = 1;
    step();
    rst = 0;
    pref = 0;
    repeat (5) step();
    chk("post_rsp0_valid", rsp0_valid, 0);
    chk("post_rsp1_valid", rsp1_valid, 0);
    chk("post_data0", rsp0_data, 0);
    chk("post_err0", rsp0_err, 0);
    chk("post_busy", busy, 0);
    chk("post_start", fpu_start, 0);
    chk("post_op", fpu_op, 0);
    chk("post_a", fpu_a, 0);
    chk("post_b", fpu_b, 0);
    txn(2'b11, OP_ADD, OP_SUB, XA, XB, 1, 0);

    // Randomized operations against the reference rules
    for (int i = 0; i < 24; i++) begin
      txn(2'($urandom_range(1, 3)),
          2'($urandom), 2'($urandom),
          $urandom, $urandom,
          $urandom_range(0, TO + 2),
          $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
